// File: rtl/videomem_axil_slave.sv
// AXI4-Lite responder in front of the video frame RAM.
// One write and one read can be in flight at the same time. A separate
// read-only pixel port feeds display scan-out. RAM contents survive reset.
module videomem_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 16,
    parameter int MEM_DEPTH          = 4096,
    localparam int VW                = $clog2(MEM_DEPTH)
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    input  logic [VW-1:0]                 VID_ADDR,
    output logic [C_S_AXI_DATA_WIDTH-1:0] VID_DATA
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = DW / 8;
    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
    // Depth widened by one bit so an index equal to MEM_DEPTH compares correctly.
    localparam logic [IW:0] DEPTH_W = (IW+1)'(MEM_DEPTH);

    typedef enum logic       {W_IDLE, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_MEM, R_DATA} rstate_t;

    logic [DW-1:0] ram [MEM_DEPTH];

    wstate_t w_state, w_next;
    rstate_t r_state, r_next;

    logic          live;
    logic          aw_done, w_done;
    logic [IW-1:0] aw_idx_q;
    logic [DW-1:0] w_data_q;
    logic [NB-1:0] w_strb_q;
    logic [1:0]    bresp_q;

    logic [VW-1:0] ar_idx_q;
    logic          ar_oor_q;
    logic [1:0]    rresp_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] vid_q;

    logic          aw_fire, w_fire, ar_fire, have_aw, have_w, wr_commit, wr_oor, ar_oor;
    logic [IW-1:0] wr_idx;
    logic [DW-1:0] wr_data;
    logic [NB-1:0] wr_strb;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_fire = S_AXI_AWVALID && S_AXI_AWREADY && !ARESET;
    assign w_fire  = S_AXI_WVALID  && S_AXI_WREADY  && !ARESET;
    assign ar_fire = S_AXI_ARVALID && S_AXI_ARREADY && !ARESET;
    assign have_aw = aw_done || aw_fire;
    assign have_w  = w_done  || w_fire;

    // Take each half of the write from its register if already captured, else straight from the bus.
    assign wr_idx    = aw_done ? aw_idx_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_data   = w_done  ? w_data_q : S_AXI_WDATA;
    assign wr_strb   = w_done  ? w_strb_q : S_AXI_WSTRB;
    assign wr_oor    = {1'b0, wr_idx} >= DEPTH_W;
    assign wr_commit = (w_state == W_IDLE) && have_aw && have_w && !ARESET;
    assign ar_oor    = {1'b0, S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]} >= DEPTH_W;

    // Holds readys low for the cycle in which reset is released.
    always_ff @(posedge ACLK) begin
        live <= !ARESET;
    end

    // Write FSM state register.
    always_ff @(posedge ACLK) begin
        if (ARESET) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    // Write FSM next state.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (wr_commit) w_next = W_RESP;
            W_RESP:  if (S_AXI_BREADY) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Write FSM outputs.
    always_comb begin
        S_AXI_AWREADY = live && (w_state == W_IDLE) && !aw_done;
        S_AXI_WREADY  = live && (w_state == W_IDLE) && !w_done;
        S_AXI_BVALID  = (w_state == W_RESP);
        S_AXI_BRESP   = bresp_q;
    end

    // Capture AW and W independently; release both flags when the pair commits.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bresp_q <= 2'b00;
        end else if (wr_commit) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bresp_q <= wr_oor ? 2'b10 : 2'b00;
        end else begin
            if (aw_fire) begin
                aw_done  <= 1'b1;
                aw_idx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_fire) begin
                w_done   <= 1'b1;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
        end
    end

    // RAM write port with byte enables; out-of-range commits leave memory alone.
    always_ff @(posedge ACLK) begin
        if (wr_commit && !wr_oor) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_strb[i]) ram[wr_idx[VW-1:0]][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge ACLK) begin
        if (ARESET) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    // Read FSM next state.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_fire) r_next = R_MEM;
            R_MEM:   r_next = R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read FSM outputs.
    always_comb begin
        S_AXI_ARREADY = live && (r_state == R_IDLE);
        S_AXI_RVALID  = (r_state == R_DATA);
        S_AXI_RRESP   = rresp_q;
        S_AXI_RDATA   = rdata_q;
    end

    // Latch the read index, then do a registered RAM read (old data on a same-edge write).
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rdata_q <= '0;
            rresp_q <= 2'b00;
        end else begin
            if (ar_fire) begin
                ar_idx_q <= S_AXI_ARADDR[VW+1:2];
                ar_oor_q <= ar_oor;
            end
            if (r_state == R_MEM) begin
                rdata_q <= ar_oor_q ? '0 : ram[ar_idx_q];
                rresp_q <= ar_oor_q ? 2'b10 : 2'b00;
            end
        end
    end

    // Pixel port: free-running registered read, independent of the AXI side.
    always_ff @(posedge ACLK) begin
        if (ARESET) vid_q <= '0;
        else        vid_q <= ram[VID_ADDR];
    end

    assign VID_DATA = vid_q;

endmodule

// File: tb/tb_videomem_axil_slave.sv
// Bench for videomem_axil_slave: a byte-level RAM model feeds expected B and R
// responses into queues as requests go out; tests pop them when the DUT answers.
module tb_videomem_axil_slave;

    localparam int AW    = 16;
    localparam int DEPTH = 4096;
    localparam int VW    = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [2:0]    awprot = 3'd0, arprot = 3'd0;
    logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic          bready = 1'b1, rready = 1'b1;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic [VW-1:0] vid_addr = '0;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [1:0]    bresp, rresp;
    logic [31:0]   rdata, vid_data;

    int total = 0;
    int bad   = 0;

    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];      // {rresp, rdata}
    logic [31:0] mem_m[int];    // bench's own picture of RAM

    always #5 clk = ~clk;

    videomem_axil_slave dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .VID_ADDR(vid_addr), .VID_DATA(vid_data)
    );

    // Push the expected B response, update the model, run the AW/W handshakes.
    // lead > 0 presents W that many cycles ahead of AW. Returns #1 after the commit edge.
    task automatic issue_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
        int idx;
        logic [31:0] w;
        idx = int'(a[15:2]);
        if (idx >= DEPTH) exp_b.push_back(2'b10);
        else begin
            w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
            for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
            mem_m[idx] = w;
            exp_b.push_back(2'b00);
        end
        awaddr = a; wdata = d; wstrb = s;
        if (lead > 0) begin
            wvalid = 1'b1;
            for (int n = 0; n < 20 && wready !== 1'b1; n++) begin @(posedge clk); #1; end
            total++;
            if (wready !== 1'b1) begin bad++; $display("FAIL w_accept wready=%b want 1", wready); end
            @(posedge clk); #1;
            wvalid = 1'b0;
            repeat (lead - 1) begin @(posedge clk); #1; end
            // W is parked: no response and no second W accepted until AW shows up
            total++;
            if ({bvalid, wready, awready} !== 3'b001) begin
                bad++; $display("FAIL w_parked bvalid/wready/awready=%b want 001", {bvalid, wready, awready});
            end
            awvalid = 1'b1;
            for (int n = 0; n < 20 && awready !== 1'b1; n++) begin @(posedge clk); #1; end
            total++;
            if (awready !== 1'b1) begin bad++; $display("FAIL aw_accept awready=%b want 1", awready); end
            @(posedge clk); #1;
            awvalid = 1'b0;
        end else begin
            awvalid = 1'b1; wvalid = 1'b1;
            for (int n = 0; n < 20 && (awready & wready) !== 1'b1; n++) begin @(posedge clk); #1; end
            total++;
            if ((awready & wready) !== 1'b1) begin
                bad++; $display("FAIL aww_accept awready=%b wready=%b want 1 1", awready, wready);
            end
            @(posedge clk); #1;
            awvalid = 1'b0; wvalid = 1'b0;
        end
    endtask

    // Push the expected R response and run the AR handshake. Returns #1 after the AR edge.
    task automatic issue_read(input logic [15:0] a);
        int idx;
        idx = int'(a[15:2]);
        if (idx >= DEPTH) exp_r.push_back({2'b10, 32'h0});
        else              exp_r.push_back({2'b00, mem_m[idx]});
        araddr = a; arvalid = 1'b1;
        for (int n = 0; n < 20 && arready !== 1'b1; n++) begin @(posedge clk); #1; end
        total++;
        if (arready !== 1'b1) begin bad++; $display("FAIL ar_accept arready=%b want 1", arready); end
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, vid_data} !== 73'h0) begin
            bad++;
            $display("FAIL rst_hold rdy=%b%b%b bv=%b rv=%b br=%b rr=%b rd=%h vid=%h want all 0",
                     awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, vid_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
            bad++; $display("FAIL rst_release aw/w/ar/bv/rv=%b want 11100", {awready, wready, arready, bvalid, rvalid});
        end
    endtask

    task automatic test_write_read();
        logic [1:0]  eb;
        logic [33:0] er;
        issue_write(16'h0010, 32'hDEADBEEF, 4'b1111, 0);
        eb = exp_b.pop_front();
        total++;
        if (bvalid !== 1'b1 || bresp !== eb) begin
            bad++; $display("FAIL wr_b bvalid=%b bresp=%b want 1 %b", bvalid, bresp, eb);
        end
        @(posedge clk); #1;
        total++;
        if ({bvalid, awready, wready} !== 3'b011) begin
            bad++; $display("FAIL wr_reopen bv/aw/w=%b want 011", {bvalid, awready, wready});
        end
        issue_read(16'h0010);
        total++;
        if (rvalid !== 1'b0) begin bad++; $display("FAIL rd_early rvalid=%b want 0", rvalid); end
        @(posedge clk); #1;
        er = exp_r.pop_front();
        total++;
        if (rvalid !== 1'b1 || {rresp, rdata} !== er) begin
            bad++; $display("FAIL rd_data rvalid=%b rresp=%b rdata=%h want 1 %b %h", rvalid, rresp, rdata, er[33:32], er[31:0]);
        end
        @(posedge clk); #1;
        total++;
        if ({rvalid, arready} !== 2'b01) begin bad++; $display("FAIL rd_reopen rv/ar=%b want 01", {rvalid, arready}); end
        vid_addr = 12'd4;
        @(posedge clk); #1;
        total++;
        if (vid_data !== 32'hDEADBEEF) begin bad++; $display("FAIL vid_read vid=%h want deadbeef", vid_data); end
    endtask

    task automatic test_strobe();
        logic [1:0]  eb;
        logic [33:0] er;
        issue_write(16'h0010, 32'h11223344, 4'b0101, 3);
        eb = exp_b.pop_front();
        total++;
        if (bvalid !== 1'b1 || bresp !== eb) begin
            bad++; $display("FAIL strb_b bvalid=%b bresp=%b want 1 %b", bvalid, bresp, eb);
        end
        @(posedge clk); #1;
        issue_read(16'h0012);   // low address bits ignored
        @(posedge clk); #1;
        er = exp_r.pop_front();
        total++;
        if (rvalid !== 1'b1 || {rresp, rdata} !== er || rdata !== 32'hDE22BE44) begin
            bad++; $display("FAIL strb_rd rvalid=%b rresp=%b rdata=%h want 1 %b de22be44", rvalid, rresp, rdata, er[33:32]);
        end
        @(posedge clk); #1;
        // Empty strobe: OKAY, nothing changes
        issue_write(16'h0010, 32'hFFFFFFFF, 4'b0000, 0);
        eb = exp_b.pop_front();
        total++;
        if (bvalid !== 1'b1 || bresp !== eb) begin
            bad++; $display("FAIL strb0_b bvalid=%b bresp=%b want 1 %b", bvalid, bresp, eb);
        end
        @(posedge clk); #1;
        vid_addr = 12'd4;
        @(posedge clk); #1;
        total++;
        if (vid_data !== mem_m[4]) begin bad++; $display("FAIL strb0_vid vid=%h want %h", vid_data, mem_m[4]); end
    endtask

    task automatic test_out_of_range();
        logic [1:0]  eb;
        logic [33:0] er;
        issue_write(16'h0000, 32'hA5A50F0F, 4'b1111, 0);
        eb = exp_b.pop_front();
        total++;
        if (bvalid !== 1'b1 || bresp !== eb) begin bad++; $display("FAIL oor_pre_b bresp=%b want %b", bresp, eb); end
        @(posedge clk); #1;
        // index 4096 would alias word 0 if the range check were missing
        issue_write(16'h4000, 32'hFFFFFFFF, 4'b1111, 0);
        eb = exp_b.pop_front();
        total++;
        if (bvalid !== 1'b1 || bresp !== eb) begin
            bad++; $display("FAIL oor_b bvalid=%b bresp=%b want 1 %b", bvalid, bresp, eb);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            issue_read(k == 0 ? 16'h4000 : 16'h0000);
            @(posedge clk); #1;
            er = exp_r.pop_front();
            total++;
            if (rvalid !== 1'b1 || {rresp, rdata} !== er) begin
                bad++; $display("FAIL oor_rd%0d rvalid=%b rresp=%b rdata=%h want 1 %b %h", k, rvalid, rresp, rdata, er[33:32], er[31:0]);
            end
            @(posedge clk); #1;
        end
        vid_addr = 12'd0;
        @(posedge clk); #1;
        total++;
        if (vid_data !== 32'hA5A50F0F) begin bad++; $display("FAIL oor_vid vid=%h want a5a50f0f", vid_data); end
    endtask

    task automatic test_backpressure();
        logic [1:0]  eb;
        logic [33:0] er;
        bready = 1'b0; rready = 1'b0;
        issue_write(16'h0020, 32'h0BADF00D, 4'b1111, 0);
        issue_read(16'h0010);
        @(posedge clk); #1;
        eb = exp_b.pop_front();
        er = exp_r.pop_front();
        for (int c = 0; c < 10; c++) begin
            total++;
            if ({bvalid, bresp, rvalid, rresp, rdata, awready, wready, arready} !== {1'b1, eb, 1'b1, er, 3'b000}) begin
                bad++;
                $display("FAIL bp_hold%0d bv=%b br=%b rv=%b rr=%b rd=%h rdy=%b%b%b want 1 %b 1 %b %h 000",
                         c, bvalid, bresp, rvalid, rresp, rdata, awready, wready, arready, eb, er[33:32], er[31:0]);
            end
            @(posedge clk); #1;
        end
        bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) begin
            bad++; $display("FAIL bp_release bv/rv/aw/w/ar=%b want 00111", {bvalid, rvalid, awready, wready, arready});
        end
    endtask

    task automatic test_reset_mid();
        logic [33:0] er;
        bready = 1'b0; rready = 1'b0;
        issue_write(16'h0030, 32'h12345678, 4'b1111, 0);
        issue_read(16'h0020);
        @(posedge clk); #1;
        total++;
        if ({bvalid, rvalid} !== 2'b11) begin bad++; $display("FAIL mid_setup bv/rv=%b want 11", {bvalid, rvalid}); end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({bvalid, rvalid, awready, wready, arready, rdata} !== 37'h0) begin
            bad++; $display("FAIL mid_rst bv/rv/aw/w/ar=%b rd=%h want 00000 0", {bvalid, rvalid, awready, wready, arready}, rdata);
        end
        exp_b.delete();
        exp_r.delete();
        rst = 1'b0; bready = 1'b1; rready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++;
            if ({bvalid, rvalid} !== 2'b00) begin
                bad++; $display("FAIL mid_silent%0d bv/rv=%b want 00", c, {bvalid, rvalid});
            end
        end
        for (int k = 0; k < 3; k++) begin
            issue_read(k == 0 ? 16'h0030 : (k == 1 ? 16'h0010 : 16'h0020));
            @(posedge clk); #1;
            er = exp_r.pop_front();
            total++;
            if (rvalid !== 1'b1 || {rresp, rdata} !== er) begin
                bad++; $display("FAIL mid_keep%0d rvalid=%b rresp=%b rdata=%h want 1 %b %h", k, rvalid, rresp, rdata, er[33:32], er[31:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobe();
        test_out_of_range();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/videomem_axil_slave.md
Name: videomem_axil_slave

Overview:
AXI4-Lite responder fronting the video frame memory; it is the slave-side counterpart of the M00_AXI pattern-generator master. It accepts single-beat writes and reads from the PS/master into an internal word-addressed RAM and exposes an independent read-only pixel port for the display scan-out logic. One outstanding write and one outstanding read, serviced concurrently.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; fixed at 32 (4 byte lanes)
C_S_AXI_ADDR_WIDTH, 16, AXI byte-address width
MEM_DEPTH, 4096, RAM depth in 32-bit words; power of 2; VW = log2(MEM_DEPTH)

Ports:
ACLK  in  1  sole clock; all logic rising-edge
ARESET  in  1  synchronous, active-high reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write byte address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read byte address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
VID_ADDR  in  VW  pixel word index
VID_DATA  out  32  pixel word, registered

Behaviour:
- Reset (ARESET=1 at an edge): AWREADY/WREADY/ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=00, RDATA=0, VID_DATA=0, capture flags cleared, both FSMs to IDLE. RAM contents NOT cleared. Reset mid-transaction abandons it silently; no response issued afterwards. Readys go high the first cycle after ARESET deasserts.
- Address decode: word index = ADDR[C_S_AXI_ADDR_WIDTH-1:2]; ADDR[1:0] ignored. Index >= MEM_DEPTH is out-of-range.
- Write FSM states W_IDLE, W_RESP.
  - W_IDLE: AWREADY=1 while AW not yet captured; WREADY=1 while W not yet captured; AW and W accepted independently in any order or same cycle, each held in a register once accepted (its ready drops next cycle).
  - At the edge where the pair becomes complete: in-range -> RAM bytes written where WSTRB[i]=1, BRESP=00; out-of-range -> no RAM change, BRESP=10. Flags clear, go W_RESP; BVALID=1 next cycle.
  - W_RESP: AWREADY=WREADY=0, BVALID=1 with BRESP stable until BVALID&BREADY; then W_IDLE, readys high next cycle.
  - Latency: AW+W same cycle N -> BVALID in N+1; with BREADY held high, next AW/W accepted in N+2.
  - WSTRB=0000 in range: no RAM change, OKAY.
- Read FSM states R_IDLE, R_MEM, R_DATA.
  - R_IDLE: ARREADY=1; on handshake latch index -> R_MEM.
  - R_MEM: ARREADY=0; registered RAM read -> R_DATA.
  - R_DATA: RVALID=1; RDATA=word, RRESP=00 in range; RDATA=0, RRESP=10 out-of-range. RDATA/RRESP held stable until RVALID&RREADY -> R_IDLE.
  - Latency: AR at cycle N -> RVALID in N+2.
- Read and write channels operate concurrently. RAM read in R_MEM on the same edge as a write commit to the same word returns OLD data (read-before-write).
- Video port: VID_DATA <= RAM[VID_ADDR] every cycle, 1-cycle latency, no handshake, independent of AXI. Same-edge collision with an AXI write returns old data; new data appears on the following read.
- AWPROT/ARPROT ignored; no interleaving or exclusive access; RAM inferred as dual-port block RAM.

Test Plan:
- Reset then idle: after ARESET drops, AWREADY=WREADY=ARREADY=1, BVALID=RVALID=0, VID_DATA=0.
- Write 0xDEADBEEF to 0x0010 with AW+W same cycle, WSTRB=1111, BREADY=1 -> BVALID 1 cycle later with BRESP=00. Read 0x0010 -> RVALID 2 cycles after AR with RDATA=0xDEADBEEF, RRESP=00. VID_ADDR=4 -> VID_DATA=0xDEADBEEF next cycle.
- W 3 cycles before AW, WSTRB=0101, data 0x11223344 over 0xDEADBEEF at 0x0010 -> single BVALID after AW accepted; readback 0xDE22BE44.
- Out-of-range write/read at 0x4000 (index 4096) -> BRESP=10, RAM unchanged; read gives RRESP=10, RDATA=0.
- Backpressure: hold BREADY=0 and RREADY=0 for 10 cycles -> BVALID/RVALID, BRESP/RRESP, RDATA stable; AWREADY/WREADY/ARREADY stay 0; responses complete on release.
- Reset asserted in W_RESP and R_DATA -> BVALID=RVALID=0 next cycle. Previously written RAM words still read back unchanged.
